// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: truth-table sweep controller for a 3-input combinational block.
// Steps the block inputs {x3,x2,x1} through rows 0..7. Each row is driven for
// SETTLE cycles and then sampled for one cycle. Every sampled {f,a,b,c} nibble
// is stored in capture and compared against the matching nibble of expect_tbl.
// Optional build macro: TT_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first
// mismatching row; rows after that row are left at 0 in capture.
module tt_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] expect_tbl,
  input  logic        dut_f,
  input  logic        dut_a,
  input  logic        dut_b,
  input  logic        dut_c,
  output logic        x3,
  output logic        x2,
  output logic        x1,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_cnt,
  output logic [2:0]  first_fail,
  output logic [31:0] capture
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  row;
  logic [3:0]  settle_cnt;
  logic [4:0]  nib_base;
  logic [3:0]  sample_nib;
  logic [3:0]  expect_nib;
  logic        mismatch;
  logic        end_sweep;

  assign nib_base   = {row, 2'b00};
  assign sample_nib = {dut_f, dut_a, dut_b, dut_c};
  assign expect_nib = expect_tbl[nib_base +: 4];
  assign mismatch   = (state == SAMPLE) && (sample_nib != expect_nib);
  assign {x3, x2, x1} = row;

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
  assign end_sweep = (row == 3'd7) || mismatch;
`else
  assign end_sweep = (row == 3'd7);
`endif

  // State register; reset returns to IDLE and takes priority over start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection and the status outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (settle_cnt <= 4'd1) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (end_sweep) state_nxt = DONE;
        else           state_nxt = DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row index, settle counter and the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= 3'd0;
      settle_cnt <= 4'd0;
      pass       <= 1'b0;
      fail_cnt   <= 4'd0;
      first_fail <= 3'd0;
      capture    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row        <= 3'd0;
            settle_cnt <= SETTLE_LD;
            pass       <= 1'b0;
            fail_cnt   <= 4'd0;
            first_fail <= 3'd0;
            capture    <= 32'd0;
          end
        end
        DRIVE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          capture[nib_base +: 4] <= sample_nib;
          if (mismatch) begin
            fail_cnt <= fail_cnt + 4'd1;
            if (fail_cnt == 4'd0) first_fail <= row;
          end
          if (!end_sweep) begin
            row        <= row + 3'd1;
            settle_cnt <= SETTLE_LD;
          end
        end
        DONE: begin
          pass <= (fail_cnt == 4'd0);
          row  <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Testbench for tt_sweep_ctrl with SETTLE=2 and a small reference block under
// sweep. It runs a table of sweeps, then hand-written reset/start sequences.
module tb_tt_sweep_ctrl;

  localparam int S   = 2;
  localparam int LAT = 8 * (S + 1) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] expect_tbl;
  logic        dut_f, dut_a, dut_b, dut_c;
  logic        x3, x2, x1;
  logic        busy, done, pass;
  logic [3:0]  fail_cnt;
  logic [2:0]  first_fail;
  logic [31:0] capture;

  int checks  = 0;
  int errors  = 0;
  int seq_bad = 0;

  typedef struct {
    logic [31:0] tbl;
    logic [31:0] cap;
    logic        exp_pass;
    logic [3:0]  exp_fc;
    logic [2:0]  exp_ff;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] correct;

  tt_sweep_ctrl #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .expect_tbl(expect_tbl),
    .dut_f(dut_f), .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
    .x3(x3), .x2(x2), .x1(x1), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .first_fail(first_fail), .capture(capture)
  );

  always #5 clk = ~clk;

  // Reference 3-input combinational block driven by the controller.
  always_comb begin
    dut_f = x3 ^ x2 ^ x1;
    dut_a = x3 & x2;
    dut_b = x2 | x1;
    dut_c = ~x3;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Starts one sweep from IDLE (called at a negedge). The cycle with start high
  // is the accept cycle; lat counts cycles from it to the cycle with done high.
  task automatic applyStimulus(input logic [31:0] tbl, input int repulse_at,
                               output int lat, output int busy_cycles);
    int n;
    expect_tbl  = tbl;
    start       = 1'b1;
    lat         = -1;
    busy_cycles = 0;
    n           = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (repulse_at > 0 && n == repulse_at) start = 1'b1;
      if (repulse_at > 0 && n == repulse_at + 1) start = 1'b0;
      if (busy) begin
        busy_cycles++;
        if ({x3, x2, x1} != 3'((n - 1) / (S + 1))) seq_bad++;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int bc;
    logic found;
    logic [2:0] v;

    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      correct[4*i +: 4] = {^v, v[2] & v[1], v[1] | v[0], ~v[2]};
    end

    vecs[0] = '{correct, correct, 1'b1, 4'd0, 3'd0, LAT};
    vecs[4] = '{correct ^ 32'hF000_0000, correct, 1'b0, 4'd1, 3'd7, LAT};
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    vecs[1] = '{correct ^ 32'h00F0_0000, correct & 32'h00FF_FFFF, 1'b0, 4'd1, 3'd5, 6*(S+1)+1};
    vecs[2] = '{~correct, correct & 32'h0000_000F, 1'b0, 4'd1, 3'd0, 1*(S+1)+1};
    vecs[3] = '{correct ^ 32'hF000_000F, correct & 32'h0000_000F, 1'b0, 4'd1, 3'd0, 1*(S+1)+1};
    vecs[5] = '{correct ^ 32'h0000_0200, correct & 32'h0000_0FFF, 1'b0, 4'd1, 3'd2, 3*(S+1)+1};
`else
    vecs[1] = '{correct ^ 32'h00F0_0000, correct, 1'b0, 4'd1, 3'd5, LAT};
    vecs[2] = '{~correct, correct, 1'b0, 4'd8, 3'd0, LAT};
    vecs[3] = '{correct ^ 32'hF000_000F, correct, 1'b0, 4'd2, 3'd0, LAT};
    vecs[5] = '{correct ^ 32'h0000_0200, correct, 1'b0, 4'd1, 3'd2, LAT};
`endif

    rst = 1'b1; start = 1'b0; expect_tbl = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_pass", {31'd0, pass}, 32'd0);
    checkOutput("rst_x", {29'd0, x3, x2, x1}, 32'd0);
    checkOutput("rst_fc", {28'd0, fail_cnt}, 32'd0);
    checkOutput("rst_cap", capture, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].tbl, 0, lat, bc);
      checkOutput($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_busy", i), 32'(bc), 32'(vecs[i].exp_lat - 1));
      checkOutput($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
      checkOutput($sformatf("v%0d_fc", i), {28'd0, fail_cnt}, {28'd0, vecs[i].exp_fc});
      checkOutput($sformatf("v%0d_ff", i), {29'd0, first_fail}, {29'd0, vecs[i].exp_ff});
      checkOutput($sformatf("v%0d_cap", i), capture, vecs[i].cap);
      checkOutput($sformatf("v%0d_xidle", i), {29'd0, x3, x2, x1}, 32'd0);
    end
    checkOutput("x_sequence", 32'(seq_bad), 32'd0);

    repeat (5) @(negedge clk);
    checkOutput("hold_cap", capture, vecs[5].cap);
    checkOutput("hold_fc", {28'd0, fail_cnt}, {28'd0, vecs[5].exp_fc});
    checkOutput("hold_ff", {29'd0, first_fail}, {29'd0, vecs[5].exp_ff});
    checkOutput("hold_busy", {31'd0, busy}, 32'd0);

    applyStimulus(correct, 5, lat, bc);
    checkOutput("repulse_lat", 32'(lat), 32'(LAT));
    checkOutput("repulse_pass", {31'd0, pass}, 32'd1);
    checkOutput("repulse_idle", {31'd0, busy}, 32'd0);

    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    checkOutput("rstprio_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstprio_pass", {31'd0, pass}, 32'd0);
    checkOutput("rstprio_cap", capture, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("rstprio_idle", {31'd0, busy}, 32'd0);

    expect_tbl = ~correct;
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && {x3, x2, x1} == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("mid_reach_row3", {31'd0, found}, 32'd1);
    checkOutput("mid_fc_before", {28'd0, fail_cnt}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_done", {31'd0, done}, 32'd0);
    checkOutput("mid_x", {29'd0, x3, x2, x1}, 32'd0);
    checkOutput("mid_fc", {28'd0, fail_cnt}, 32'd0);
    checkOutput("mid_ff", {29'd0, first_fail}, 32'd0);
    checkOutput("mid_cap", capture, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_idle", {31'd0, busy}, 32'd0);

    applyStimulus(correct, 0, lat, bc);
    checkOutput("fresh_lat", 32'(lat), 32'(LAT));
    checkOutput("fresh_pass", {31'd0, pass}, 32'd1);
    checkOutput("fresh_fc", {28'd0, fail_cnt}, 32'd0);
    checkOutput("fresh_cap", capture, correct);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2, legal range 1..15: number of clock cycles a row is driven before its outputs are sampled.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request one full sweep; accepted only in IDLE.
REQ-005 SHALL have port expect_tbl, input, 32 bits: expected outputs; row i occupies bits [4i+3:4i] packed as {f,a,b,c}.
REQ-006 SHALL have ports dut_f, dut_a, dut_b, dut_c, input, 1 bit each: outputs of the 3-input combinational block under sweep.
REQ-007 SHALL have ports x3, x2, x1, output, 1 bit each: drive of the block inputs; {x3,x2,x1} equals the current row index i.
REQ-008 SHALL have port busy, output, 1 bit: high while in DRIVE or SAMPLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a sweep ends.
REQ-010 SHALL have port pass, output, 1 bit: high when the last completed sweep had zero mismatches.
REQ-011 SHALL have port fail_cnt, output, 4 bits: number of mismatching rows, 0..8.
REQ-012 SHALL have port first_fail, output, 3 bits: index of the lowest mismatching row; 0 when none.
REQ-013 SHALL have port capture, output, 32 bits: sampled {f,a,b,c} per row, same packing as expect_tbl.

Function
REQ-014 SHALL implement the states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 SHALL, in IDLE with start=1, clear fail_cnt, first_fail, capture and pass; set row index to 0; load the settle counter with SETTLE; and move to DRIVE.
REQ-016 SHALL, in DRIVE, decrement the settle counter each cycle and move to SAMPLE in the cycle after the counter reaches 1, so each row is driven for exactly SETTLE cycles.
REQ-017 SHALL, in SAMPLE, write {dut_f,dut_a,dut_b,dut_c} into capture[4i+3:4i] and compare it against expect_tbl[4i+3:4i].
REQ-018 SHALL, on a SAMPLE mismatch, increment fail_cnt and, if this is the first mismatch, set first_fail to i.
REQ-019 SHALL, leaving SAMPLE with i<7, increment i, reload SETTLE and return to DRIVE; with i=7 it SHALL go to DONE.
REQ-020 SHALL keep x3..x1 stable across the DRIVE and SAMPLE cycles of a row and change them only on entry to the next row's DRIVE.
REQ-021 SHALL, in DONE, assert done for one cycle, set pass=(fail_cnt==0), and return to IDLE.
REQ-022 SHALL, absent any abort, give start-accept-to-done latency of 8*(SETTLE+1)+1 cycles, with busy high for 8*(SETTLE+1) cycles.
REQ-023 SHALL ignore start in DRIVE, SAMPLE and DONE; a start held high from DONE into IDLE begins a new sweep.
REQ-024 SHALL hold results (pass, fail_cnt, first_fail, capture) stable in IDLE until the next accepted start.
REQ-025 SHALL sample expect_tbl live in each SAMPLE cycle; the user keeps it stable during busy.
REQ-026 SHALL saturate neither fail_cnt nor the row index, since fail_cnt ≤ 8 fits in 4 bits and the row index wraps only via the DONE exit.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, including mid-sweep, enter IDLE and zero x3..x1, busy, done, pass, fail_cnt, first_fail, capture, the row index and the settle counter.
REQ-028 SHALL give rst priority over start in the same cycle.

Configuration
REQ-029 SHALL, with macro TT_SWEEP_STOP_ON_FAIL_EN defined, go from a mismatching SAMPLE directly to DONE, leaving the remaining capture rows at 0 and fail_cnt=1.
REQ-030 SHALL, without TT_SWEEP_STOP_ON_FAIL_EN, always sweep all 8 rows regardless of mismatches.

Verification
REQ-031 SHALL verify a correct table: SETTLE=2, expect_tbl matches the block under sweep, start pulse -> done exactly 25 cycles after accept, pass=1, fail_cnt=0, capture=expect_tbl.
REQ-032 SHALL verify a single corruption: expect_tbl row 5 nibble flipped -> pass=0, fail_cnt=1, first_fail=5; with TT_SWEEP_STOP_ON_FAIL_EN, done after 6*(SETTLE+1)+1 cycles and capture[31:24]=0.
REQ-033 SHALL verify all rows wrong: expect_tbl=~correct -> fail_cnt=8, first_fail=0, pass=0 (macro undefined).
REQ-034 SHALL verify input sequencing: {x3,x2,x1} steps 0..7, each value held SETTLE+1 cycles, busy high throughout, no change mid-row.
REQ-035 SHALL verify reset and start handling: start re-pulsed during busy -> ignored, latency unchanged; rst asserted at row 3 -> next cycle all outputs 0 and state IDLE, and a fresh start completes normally.
